output_collector: RTL and testbench
===================================

// Module: output_collector
// PURPOSE
//   Downstream neighbour of the 2x2 systolic array. Captures the skewed
//   per-column accumulator streams and rebuilds the 2x2 result matrix
//   C = A x W. Converts each element from ACC_WIDTH to OUT_WIDTH with
//   signed saturation, then holds the matrix behind a valid/ready handshake.
//   Includes a watchdog that aborts a collection when the array stalls.
// PARAMETERS
//   ACC_WIDTH  32  width of array column outputs (signed two's complement)
//   OUT_WIDTH  16  width of result elements (signed, matches activation width)
//   TIMEOUT    16  max cycles in COLLECT before abort (>=4)
// PORTS
//   clk         in   1          clock, rising edge
//   reset_n     in   1          async, active-low reset
//   start       in   1          begin a new collection (pulse)
//   col1_valid  in   1          column-1 beat strobe
//   col1_data   in   ACC_WIDTH  column-1 value (beat0=c11, beat1=c21)
//   col2_valid  in   1          column-2 beat strobe
//   col2_data   in   ACC_WIDTH  column-2 value (beat0=c12, beat1=c22)
//   out_ready   in   1          consumer accepts the held matrix
//   out_valid   out  1          matrix c11..c22 valid and stable
//   c11,c12,c21,c22 out OUT_WIDTH  result elements (registered)
//   busy        out  1          state != IDLE
//   timeout     out  1          1-cycle pulse on watchdog abort
//   overflow    out  1          sticky: a beat was dropped (extra/late)
//   sat_flag    out  1          some element of the current result clipped
// BEHAVIOUR
//   - Reset (reset_n=0, async): state=IDLE; all outputs, c-regs, beat counters,
//     and timer are 0.
//   - FSM IDLE -> COLLECT on start. Entering COLLECT: per-column beat counters=0,
//     timer=0, overflow=0, sat_flag=0. Column beats in IDLE are ignored.
//   - COLLECT: each colN_valid stores data into the slot selected by that
//     column's counter (0 or 1), then increments it. Columns are independent.
//     Both columns may beat in the same cycle. A third beat on a column is
//     dropped and sets overflow. start is ignored.
//   - Conversion at capture: v>2^(OUT_WIDTH-1)-1 -> max; v<-2^(OUT_WIDTH-1) ->
//     min; otherwise truncate to OUT_WIDTH. Any clip sets sat_flag.
//   - Completion: on the edge that stores the 4th element, go to HOLD. out_valid=1
//     in the cycle after that edge (1-cycle latency from last beat).
//   - Watchdog: timer increments each COLLECT cycle. If timer==TIMEOUT-1 and the
//     matrix is not complete -> IDLE, timeout=1 for one cycle, out_valid stays 0.
//     Completion and timeout on the same edge: completion wins, no timeout pulse.
//   - HOLD: out_valid=1; c-regs and sat_flag are stable. out_valid&&out_ready ->
//     IDLE, or -> COLLECT when start is also high on that edge. Column beats in
//     HOLD are dropped and set overflow. start without out_ready is ignored.
//   - After handshake, c-regs keep their values. out_valid=0 until the next
//     completion.
//   - Reset mid-operation aborts immediately. No partial result is ever presented.
// CONFIGURATION
//   COLLECTOR_RELU_EN defined: at capture, negative values become 0 before the
//     saturation check; negatives never set sat_flag.
//   Undefined: signed values pass through saturation unchanged.
// TESTING
//   1 Reset: reset_n=0 mid-COLLECT -> all outputs 0 asynchronously, busy=0.
//   2 Nominal skew: start@t0; col1 beats 5,7 @t1,t2; col2 beats 6,8 @t2,t3
//     -> out_valid@t4, c11=5 c21=7 c12=6 c22=8, sat_flag=0.
//   3 Saturation: col1 beat0=40000, beat1=-40000 -> c11=32767, c21=-32768,
//     sat_flag=1. With RELU_EN: c21=0.
//   4 Backpressure: out_ready=0 for 5 cycles; extra col2 beat during HOLD
//     -> outputs stable, overflow=1; out_ready=1 -> IDLE next cycle.
//   5 Watchdog: start, only 3 beats, TIMEOUT=16 -> timeout pulse 16 cycles
//     after start, out_valid never 1, busy=0.
//   6 Back-to-back: out_ready=1 && start=1 in HOLD -> COLLECT directly;
//     second matrix collected and presented correctly.

Source files
------------

// File: rtl/output_collector.sv
// -----------------------------------------------------------------------------
// output_collector
//
// Sits downstream of the 2x2 systolic array. The array emits each column's
// accumulators as a skewed two-beat stream (column 1: c11 then c21, column 2:
// c12 then c22). This block captures both streams, narrows every element from
// ACC_WIDTH to OUT_WIDTH with signed saturation, and presents the complete
// 2x2 result behind a valid/ready handshake. A watchdog abandons a collection
// that does not complete within TIMEOUT cycles.
//
// Build option:
//   COLLECTOR_RELU_EN  when defined, negative accumulators are forced to 0
//                      before saturation (so negatives never flag a clip).
//                      When undefined, signed values saturate unchanged.
//
// Parameters:
//   ACC_WIDTH  width of the array column outputs (signed)
//   OUT_WIDTH  width of result elements (signed)
//   TIMEOUT    max cycles spent collecting before abort (>= 4)
//
// Ports:
//   clk                 rising-edge clock
//   reset_n             asynchronous, active-low reset
//   start               pulse: begin a new collection
//   col1_valid/data     column-1 beats (beat0 = c11, beat1 = c21)
//   col2_valid/data     column-2 beats (beat0 = c12, beat1 = c22)
//   out_ready           consumer accepts the held matrix
//   out_valid           c11..c22 hold a complete, stable result
//   c11,c12,c21,c22     registered result elements
//   busy                collector is not idle
//   timeout             one-cycle pulse when the watchdog aborts
//   overflow            sticky: a beat was dropped (third beat or beat in HOLD)
//   sat_flag            an element of the current result was clipped
// -----------------------------------------------------------------------------
module output_collector #(
    parameter int ACC_WIDTH = 32,
    parameter int OUT_WIDTH = 16,
    parameter int TIMEOUT   = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 col1_valid,
    input  logic [ACC_WIDTH-1:0] col1_data,
    input  logic                 col2_valid,
    input  logic [ACC_WIDTH-1:0] col2_data,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [OUT_WIDTH-1:0] c11,
    output logic [OUT_WIDTH-1:0] c12,
    output logic [OUT_WIDTH-1:0] c21,
    output logic [OUT_WIDTH-1:0] c22,
    output logic                 busy,
    output logic                 timeout,
    output logic                 overflow,
    output logic                 sat_flag
);

    localparam int TW = $clog2(TIMEOUT);
    localparam logic signed [ACC_WIDTH-1:0] OUT_MAX = ACC_WIDTH'(2 ** (OUT_WIDTH - 1) - 1);
    localparam logic signed [ACC_WIDTH-1:0] OUT_MIN = ~OUT_MAX;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    // Returns {clipped, narrowed_value}.
    function automatic logic [OUT_WIDTH:0] sat_conv(input logic signed [ACC_WIDTH-1:0] v_in);
        logic signed [ACC_WIDTH-1:0] v;
        logic [OUT_WIDTH:0]          r;
        v = v_in;
`ifdef COLLECTOR_RELU_EN
        if (v < 0) begin
            v = '0;
        end
`endif
        if (v > OUT_MAX) begin
            r = {1'b1, OUT_MAX[OUT_WIDTH-1:0]};
        end else if (v < OUT_MIN) begin
            r = {1'b1, OUT_MIN[OUT_WIDTH-1:0]};
        end else begin
            r = {1'b0, v[OUT_WIDTH-1:0]};
        end
        return r;
    endfunction

    // Column-indexed views of the two input streams (index 0 = column 1).
    logic [1:0]                  col_valid;
    logic [1:0][ACC_WIDTH-1:0]   col_data;
    logic [1:0][OUT_WIDTH:0]     conv_res;

    assign col_valid = {col2_valid, col1_valid};
    assign col_data  = {col2_data, col1_data};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : gen_conv
            assign conv_res[gi] = sat_conv(col_data[gi]);
        end
    endgenerate

    state_t                            state_reg, state_next;
    logic [1:0][1:0]                   cnt_reg, cnt_next;      // beats taken per column (0..2)
    logic [TW-1:0]                     timer_reg, timer_next;
    // Staging slots [column][beat]; the visible c-regs load only on completion
    // so a partial collection never disturbs the presented result.
    logic [1:0][1:0][OUT_WIDTH-1:0]    slot_reg, slot_next;
    logic [1:0][1:0][OUT_WIDTH-1:0]    c_reg, c_next;
    logic                              timeout_reg, timeout_next;
    logic                              overflow_reg, overflow_next;
    logic                              sat_reg, sat_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            timer_reg    <= '0;
            slot_reg     <= '0;
            c_reg        <= '0;
            timeout_reg  <= 1'b0;
            overflow_reg <= 1'b0;
            sat_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            timer_reg    <= timer_next;
            slot_reg     <= slot_next;
            c_reg        <= c_next;
            timeout_reg  <= timeout_next;
            overflow_reg <= overflow_next;
            sat_reg      <= sat_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        timer_next    = timer_reg;
        slot_next     = slot_reg;
        c_next        = c_reg;
        timeout_next  = 1'b0;
        overflow_next = overflow_reg;
        sat_next      = sat_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next    = COLLECT;
                    cnt_next      = '0;
                    timer_next    = '0;
                    overflow_next = 1'b0;
                    sat_next      = 1'b0;
                end
            end

            COLLECT: begin
                timer_next = timer_reg + TW'(1);
                for (int c = 0; c < 2; c++) begin
                    if (col_valid[c]) begin
                        if (cnt_reg[c] == 2'd2) begin
                            overflow_next = 1'b1;
                        end else begin
                            slot_next[c][cnt_reg[c][0]] = conv_res[c][OUT_WIDTH-1:0];
                            cnt_next[c] = cnt_reg[c] + 2'd1;
                            if (conv_res[c][OUT_WIDTH]) begin
                                sat_next = 1'b1;
                            end
                        end
                    end
                end
                // Completion is judged on post-capture counts so that a final
                // beat landing on the watchdog edge still wins.
                if (cnt_next[0] == 2'd2 && cnt_next[1] == 2'd2) begin
                    state_next = HOLD;
                    c_next     = slot_next;
                end else if (timer_reg == TW'(TIMEOUT - 1)) begin
                    state_next   = IDLE;
                    timeout_next = 1'b1;
                end
            end

            HOLD: begin
                if (|col_valid) begin
                    overflow_next = 1'b1;
                end
                if (out_ready) begin
                    if (start) begin
                        // Entering a fresh collection clears the status flags,
                        // including any beat dropped on this same edge.
                        state_next    = COLLECT;
                        cnt_next      = '0;
                        timer_next    = '0;
                        overflow_next = 1'b0;
                        sat_next      = 1'b0;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign out_valid = (state_reg == HOLD);
    assign busy      = (state_reg != IDLE);
    assign timeout   = timeout_reg;
    assign overflow  = overflow_reg;
    assign sat_flag  = sat_reg;
    assign c11       = c_reg[0][0];
    assign c21       = c_reg[0][1];
    assign c12       = c_reg[1][0];
    assign c22       = c_reg[1][1];

endmodule

// File: tb/tb_output_collector.sv
// -----------------------------------------------------------------------------
// tb_output_collector
//
// Self-checking bench for output_collector: reset state, a table of matrices
// with fixed expected results, hand-written corner sequences (backpressure,
// watchdog, completion on the watchdog edge, third-beat overflow, back-to-back
// handshake, asynchronous reset mid-collection) and randomized matrices whose
// expected results come from a saturation model kept in this file.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_output_collector;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        col1_valid;
    logic [31:0] col1_data;
    logic        col2_valid;
    logic [31:0] col2_data;
    logic        out_ready;
    logic        out_valid;
    logic [15:0] c11, c12, c21, c22;
    logic        busy;
    logic        timeout;
    logic        overflow;
    logic        sat_flag;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    output_collector #(
        .ACC_WIDTH(32),
        .OUT_WIDTH(16),
        .TIMEOUT  (16)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .col1_valid(col1_valid),
        .col1_data (col1_data),
        .col2_valid(col2_valid),
        .col2_data (col2_data),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .c11       (c11),
        .c12       (c12),
        .c21       (c21),
        .c22       (c22),
        .busy      (busy),
        .timeout   (timeout),
        .overflow  (overflow),
        .sat_flag  (sat_flag)
    );

    typedef struct {
        int a11, a21, a12, a22;
        int skew;
        int e11, e21, e12, e22;
        bit esat;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: optional ReLU, then clamp to the signed 16-bit range.
    function automatic int model_sat(input int v);
        int x;
        x = v;
`ifdef COLLECTOR_RELU_EN
        if (x < 0) x = 0;
`endif
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    function automatic bit model_clip(input int v);
        int x;
        x = v;
`ifdef COLLECTOR_RELU_EN
        if (x < 0) x = 0;
`endif
        return (x > 32767) || (x < -32768);
    endfunction

    function automatic int sx(input logic [15:0] v);
        return int'($signed(v));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one matrix. Beat cycles are counted from the start edge (1-based).
    task automatic collect(input int a11, input int a21, input int a12, input int a22,
                           input int d1a, input int d1b, input int d2a, input int d2b,
                           input bit do_start, input string tag);
        int last;
        last = (d1b > d2b) ? d1b : d2b;
        if (do_start) begin
            start = 1'b1;
            step();
            start = 1'b0;
        end
        for (int k = 1; k <= last; k++) begin
            col1_valid = (k == d1a) || (k == d1b);
            col1_data  = (k == d1a) ? a11 : a21;
            col2_valid = (k == d2a) || (k == d2b);
            col2_data  = (k == d2a) ? a12 : a22;
            step();
            col1_valid = 1'b0;
            col2_valid = 1'b0;
            if (k == last - 1) check({tag, " out_valid before last beat"}, int'(out_valid), 0);
        end
        check({tag, " out_valid after last beat"}, int'(out_valid), 1);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        int got;
        bit seen_valid;
        bit pending;
        int a[4];
        int d[4];
        bit b2b;
        bit esat;

        reset_n    = 1'b0;
        start      = 1'b0;
        col1_valid = 1'b0;
        col2_valid = 1'b0;
        col1_data  = '0;
        col2_data  = '0;
        out_ready  = 1'b0;

        vecs[0] = '{5, 7, 6, 8, 1, 5, 7, 6, 8, 1'b0};
`ifdef COLLECTOR_RELU_EN
        vecs[1] = '{40000, -40000, 1, 2, 0, 32767, 0, 1, 2, 1'b1};
        vecs[2] = '{32767, -32768, -1, 0, 2, 32767, 0, 0, 0, 1'b0};
        vecs[3] = '{32768, -32769, 100000, -7, 1, 32767, 0, 32767, 0, 1'b1};
        vecs[4] = '{0, 0, -100000, 65535, 0, 0, 0, 0, 32767, 1'b1};
`else
        vecs[1] = '{40000, -40000, 1, 2, 0, 32767, -32768, 1, 2, 1'b1};
        vecs[2] = '{32767, -32768, -1, 0, 2, 32767, -32768, -1, 0, 1'b0};
        vecs[3] = '{32768, -32769, 100000, -7, 1, 32767, -32768, 32767, -7, 1'b1};
        vecs[4] = '{0, 0, -100000, 65535, 0, 0, 0, -32768, 32767, 1'b1};
`endif

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset flags {valid,busy,tmo,ovf,sat}",
              int'({out_valid, busy, timeout, overflow, sat_flag}), 0);
        check("reset c-regs", int'(c11 | c12 | c21 | c22), 0);
        reset_n = 1'b1;
        step();

        // Table-driven matrices
        foreach (vecs[i]) begin
            collect(vecs[i].a11, vecs[i].a21, vecs[i].a12, vecs[i].a22,
                    1, 2, 1 + vecs[i].skew, 2 + vecs[i].skew, 1'b1, $sformatf("vec%0d", i));
            check($sformatf("vec%0d c11", i), sx(c11), vecs[i].e11);
            check($sformatf("vec%0d c21", i), sx(c21), vecs[i].e21);
            check($sformatf("vec%0d c12", i), sx(c12), vecs[i].e12);
            check($sformatf("vec%0d c22", i), sx(c22), vecs[i].e22);
            check($sformatf("vec%0d sat_flag", i), int'(sat_flag), int'(vecs[i].esat));
            check($sformatf("vec%0d overflow", i), int'(overflow), 0);
            handshake();
            check($sformatf("vec%0d out_valid after handshake", i), int'(out_valid), 0);
            check($sformatf("vec%0d busy after handshake", i), int'(busy), 0);
            check($sformatf("vec%0d c11 retained", i), sx(c11), vecs[i].e11);
            $display("vec%0d: c11=%0d c21=%0d c12=%0d c22=%0d sat=%0b",
                     i, sx(c11), sx(c21), sx(c12), sx(c22), sat_flag);
        end

        // Backpressure with a dropped beat during HOLD
        collect(5, 7, 6, 8, 1, 2, 2, 3, 1'b1, "bp");
        for (int i = 0; i < 5; i++) begin
            col2_valid = (i == 2);
            col2_data  = 999;
            step();
            col2_valid = 1'b0;
            check("bp out_valid held", int'(out_valid), 1);
            check("bp c12 stable", sx(c12), 6);
            check("bp c22 stable", sx(c22), 8);
        end
        check("bp overflow", int'(overflow), 1);
        check("bp sat_flag", int'(sat_flag), 0);
        handshake();
        check("bp busy after handshake", int'(busy), 0);
        check("bp overflow sticky", int'(overflow), 1);
        $display("backpressure: overflow=%0b busy=%0b", overflow, busy);

        // Watchdog: only three beats arrive
        start = 1'b1;
        step();
        start = 1'b0;
        got = -1;
        seen_valid = 1'b0;
        for (int k = 1; k <= 40 && got < 0; k++) begin
            col1_valid = (k == 1) || (k == 2);
            col1_data  = 10 + k;
            col2_valid = (k == 3);
            col2_data  = 13;
            step();
            col1_valid = 1'b0;
            col2_valid = 1'b0;
            if (out_valid) seen_valid = 1'b1;
            if (timeout) got = k;
        end
        check("wd timeout cycle", got, 16);
        check("wd out_valid never", int'(seen_valid), 0);
        check("wd busy", int'(busy), 0);
        check("wd overflow cleared on start", int'(overflow), 0);
        step();
        check("wd timeout one cycle", int'(timeout), 0);
        $display("watchdog: timeout after %0d cycles", got);

        // Completion on the watchdog edge: completion wins
        collect(1, 2, 3, 4, 1, 2, 3, 16, 1'b1, "tie");
        check("tie timeout", int'(timeout), 0);
        check("tie c22", sx(c22), 4);
        handshake();
        $display("tie: out_valid won over timeout");

        // Third beat on column 1 during COLLECT is dropped
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            col1_valid = (k <= 3);
            col1_data  = (k == 1) ? 21 : ((k == 2) ? 22 : 777);
            col2_valid = (k >= 4);
            col2_data  = (k == 4) ? 23 : 24;
            step();
            col1_valid = 1'b0;
            col2_valid = 1'b0;
        end
        check("ovf out_valid", int'(out_valid), 1);
        check("ovf c11", sx(c11), 21);
        check("ovf c21", sx(c21), 22);
        check("ovf c22", sx(c22), 24);
        check("ovf overflow", int'(overflow), 1);
        handshake();
        $display("collect overflow: c21=%0d overflow=%0b", sx(c21), overflow);

        // Back-to-back: handshake and start on the same edge
        collect(50000, 20, 30, 40, 1, 2, 1, 2, 1'b1, "b2b first");
        check("b2b first c11", sx(c11), 32767);
        check("b2b first sat", int'(sat_flag), 1);
        out_ready = 1'b1;
        start     = 1'b1;
        step();
        out_ready = 1'b0;
        start     = 1'b0;
        check("b2b busy", int'(busy), 1);
        check("b2b out_valid dropped", int'(out_valid), 0);
        check("b2b sat cleared", int'(sat_flag), 0);
        collect(-3, 4, -5, 6, 1, 2, 2, 3, 1'b0, "b2b second");
        check("b2b second c11", sx(c11), model_sat(-3));
        check("b2b second c21", sx(c21), 4);
        check("b2b second c12", sx(c12), model_sat(-5));
        check("b2b second c22", sx(c22), 6);
        handshake();
        $display("back-to-back: second c11=%0d c12=%0d", sx(c11), sx(c12));

        // Randomized matrices against the model
        pending = 1'b0;
        for (int t = 0; t < 30; t++) begin
            for (int j = 0; j < 4; j++) begin
                if ($urandom_range(0, 3) == 0) a[j] = int'($urandom());
                else a[j] = int'($urandom_range(0, 100000)) - 50000;
            end
            d[0] = 1 + int'($urandom_range(0, 3));
            d[1] = d[0] + 1 + int'($urandom_range(0, 3));
            d[2] = 1 + int'($urandom_range(0, 3));
            d[3] = d[2] + 1 + int'($urandom_range(0, 3));
            collect(a[0], a[1], a[2], a[3], d[0], d[1], d[2], d[3], !pending,
                    $sformatf("rnd%0d", t));
            esat = model_clip(a[0]) | model_clip(a[1]) | model_clip(a[2]) | model_clip(a[3]);
            check($sformatf("rnd%0d c11", t), sx(c11), model_sat(a[0]));
            check($sformatf("rnd%0d c21", t), sx(c21), model_sat(a[1]));
            check($sformatf("rnd%0d c12", t), sx(c12), model_sat(a[2]));
            check($sformatf("rnd%0d c22", t), sx(c22), model_sat(a[3]));
            check($sformatf("rnd%0d sat", t), int'(sat_flag), int'(esat));
            check($sformatf("rnd%0d overflow", t), int'(overflow), 0);
            b2b = 1'($urandom_range(0, 1));
            out_ready = 1'b1;
            start     = b2b;
            step();
            out_ready = 1'b0;
            start     = 1'b0;
            check($sformatf("rnd%0d busy after handshake", t), int'(busy), int'(b2b));
            pending = b2b;
            $display("rnd%0d: in=%0d,%0d,%0d,%0d out=%0d,%0d,%0d,%0d sat=%0b",
                     t, a[0], a[1], a[2], a[3], sx(c11), sx(c21), sx(c12), sx(c22), sat_flag);
        end

        // Asynchronous reset in the middle of a collection
        collect(5, 7, 6, 8, 1, 2, 2, 3, !pending, "pre-reset");
        out_ready = 1'b1;
        start     = 1'b1;
        step();
        out_ready  = 1'b0;
        start      = 1'b0;
        col1_valid = 1'b1;
        col1_data  = 9;
        step();
        col1_valid = 1'b0;
        check("pre-reset busy", int'(busy), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async reset flags {valid,busy,tmo,ovf,sat}",
              int'({out_valid, busy, timeout, overflow, sat_flag}), 0);
        check("async reset c-regs", int'(c11 | c12 | c21 | c22), 0);
        $display("async reset: busy=%0b c11=%0d", busy, sx(c11));
        step();
        reset_n = 1'b1;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
